// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 bit mux. Four
//   requesters compete for the mux. One owner is granted at a time, the mux
//   select lines follow the owner, and the selected data bit is registered.
//   An owner may keep the mux for at most MAX_HOLD cycles while someone else
//   is waiting. When nobody else wants the mux, the owner keeps it indefinitely.
//
// Parameters
//   MAX_HOLD  cycles an owner may keep the grant under contention (1..2**HOLD_W-1)
//   HOLD_W    width of the hold counter
//
// Ports
//   clk      in   1  clock, all state changes on the rising edge
//   rst_n    in   1  synchronous active-low reset
//   req      in   4  request vector, req[i] = requester i wants the mux
//   d        in   4  mux data inputs
//   gnt      out  4  one-hot grant, all zero when idle
//   sel      out  2  mux select = index of the current or last owner
//   busy     out  1  high while a grant is active
//   z        out  1  registered mux output
//   z_valid  out  1  z holds d[sel] sampled during a grant cycle
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       z,
    output logic       z_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [1:0]        last_ptr;
    logic [HOLD_W-1:0] hold_cnt;

    // Result format {found, index}
    logic [2:0] pick_idle;
    logic [2:0] pick_next;

    // Round-robin search starting just after p. The loop runs from the
    // farthest candidate to the nearest so the nearest match wins. When
    // excl is set, p itself is never chosen.
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p,
                                           input logic       excl);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx] && !(excl && k == 4)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // pick_next excludes the current owner. Its found bit therefore means
    // "someone other than the owner is requesting". On a hand-off the owner
    // has dropped its request, so the same pick also serves that case.
    always_comb begin
        pick_idle = rr_pick(req, last_ptr, 1'b0);
        pick_next = rr_pick(req, sel, 1'b1);
    end

    // Arbitration state, grant outputs and the registered mux datapath.
    // The datapath samples the current registered busy and sel, so z
    // trails the grant by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            busy     <= 1'b0;
            z        <= 1'b0;
            z_valid  <= 1'b0;
            hold_cnt <= '0;
            last_ptr <= 2'b11;
        end else begin
            z_valid <= busy;
            z       <= busy ? d[sel] : 1'b0;

            case (state)
                IDLE: begin
                    if (pick_idle[2]) begin
                        state    <= GRANT;
                        sel      <= pick_idle[1:0];
                        gnt      <= 4'b0001 << pick_idle[1:0];
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_ONE;
                    end
                end

                GRANT: begin
                    if (!req[sel]) begin
                        last_ptr <= sel;
                        if (pick_next[2]) begin
                            sel      <= pick_next[1:0];
                            gnt      <= 4'b0001 << pick_next[1:0];
                            hold_cnt <= HOLD_ONE;
                        end else begin
                            state    <= IDLE;
                            gnt      <= 4'b0000;
                            busy     <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt == HOLD_LIMIT && pick_next[2]) begin
                        last_ptr <= sel;
                        sel      <= pick_next[1:0];
                        gnt      <= 4'b0001 << pick_next[1:0];
                        hold_cnt <= HOLD_ONE;
                    end else if (hold_cnt != HOLD_LIMIT) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Self-checking bench for mux_rr_arbiter. A behavioural model built from
//   integer owner/pointer variables predicts every output each cycle. Directed
//   sequences add fixed expected values, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       z;
    logic       z_valid;

    int checkCount;
    int errorCount;

    // Reference model state
    int  mBusy;
    int  mOwner;
    int  mLast;
    int  mHold;
    int  mZ;
    int  mZv;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .z       (z),
        .z_valid (z_valid)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. It counts each check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Searches requesters after p in circular order. When excl is set, p
    // itself is skipped. Returns -1 when no requester is found.
    function automatic int rrPick(input logic [3:0] r, input int p, input bit excl);
        int lim;
        lim = excl ? 3 : 4;
        for (int k = 1; k <= lim; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Advances the reference model by one rising edge, using the inputs
    // that were applied for that edge.
    task automatic modelStep();
        int nz;
        int nzv;
        int cand;
        if (!rst_n) begin
            mBusy = 0; mOwner = 0; mLast = 3; mHold = 0; mZ = 0; mZv = 0;
        end else begin
            nzv = mBusy;
            nz  = mBusy ? int'(d[mOwner]) : 0;
            if (mBusy == 0) begin
                cand = rrPick(req, mLast, 1'b0);
                if (cand >= 0) begin
                    mOwner = cand; mBusy = 1; mHold = 1;
                end
            end else begin
                cand = rrPick(req, mOwner, 1'b1);
                if (!req[mOwner]) begin
                    mLast = mOwner;
                    if (cand >= 0) begin
                        mOwner = cand; mHold = 1;
                    end else begin
                        mBusy = 0; mHold = 0;
                    end
                end else if (mHold == MAX_HOLD && cand >= 0) begin
                    mLast = mOwner; mOwner = cand; mHold = 1;
                end else begin
                    mHold = (mHold + 1 > MAX_HOLD) ? MAX_HOLD : mHold + 1;
                end
            end
            mZ = nz; mZv = nzv;
        end
    endtask

    // Compares every DUT output against the model.
    task automatic compareModel();
        checkOutput("gnt",     32'(gnt),     mBusy ? (32'd1 << mOwner) : 32'd0);
        checkOutput("sel",     32'(sel),     32'(mOwner));
        checkOutput("busy",    32'(busy),    32'(mBusy));
        checkOutput("z",       32'(z),       32'(mZ));
        checkOutput("z_valid", 32'(z_valid), 32'(mZv));
    endtask

    // Drives one cycle of inputs and lets one rising edge pass. Outputs are
    // then checked at the following falling edge.
    task automatic applyStimulus(input logic rn, input logic [3:0] r, input logic [3:0] dd);
        rst_n = rn;
        req   = r;
        d     = dd;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        d     = 4'b0000;
        mBusy = 0; mOwner = 0; mLast = 3; mHold = 0; mZ = 0; mZv = 0;

        // Reset with every requester asserted, then release
        applyStimulus(1'b0, 4'b1111, 4'b1111);
        applyStimulus(1'b0, 4'b1111, 4'b1111);
        checkOutput("rst_gnt",  32'(gnt),     32'h0);
        checkOutput("rst_sel",  32'(sel),     32'h0);
        checkOutput("rst_busy", 32'(busy),    32'h0);
        checkOutput("rst_z",    32'(z),       32'h0);
        checkOutput("rst_zv",   32'(z_valid), 32'h0);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        checkOutput("first_gnt", 32'(gnt), 32'h1);

        // Single requester 2, data path latency, then release
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 4'b0100);
        checkOutput("t2_gnt", 32'(gnt), 32'h4);
        checkOutput("t2_sel", 32'(sel), 32'h2);
        applyStimulus(1'b1, 4'b0100, 4'b0100);
        checkOutput("t2_z",  32'(z),       32'h1);
        checkOutput("t2_zv", 32'(z_valid), 32'h1);
        applyStimulus(1'b1, 4'b0000, 4'b0100);
        checkOutput("t2_idle_gnt",  32'(gnt),  32'h0);
        checkOutput("t2_idle_busy", 32'(busy), 32'h0);
        applyStimulus(1'b1, 4'b0000, 4'b0100);
        checkOutput("t2_idle_zv", 32'(z_valid), 32'h0);

        // Full contention: each owner keeps the grant for exactly MAX_HOLD cycles
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 4'b1111, 4'($urandom_range(0, 15)));
            checkOutput("t3_rotation", 32'(gnt), 32'd1 << ((k / MAX_HOLD) % 4));
        end

        // Owner 1 drops its request while 0 and 3 wait: hand off with no gap
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0010, 4'b0000);
        applyStimulus(1'b1, 4'b1001, 4'b0000);
        checkOutput("t4_gnt",  32'(gnt),  32'h8);
        checkOutput("t4_sel",  32'(sel),  32'h3);
        checkOutput("t4_busy", 32'(busy), 32'h1);

        // Sole requester holds indefinitely, then is preempted at once
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0010);
            checkOutput("t5_hold", 32'(gnt), 32'h2);
        end
        applyStimulus(1'b1, 4'b0011, 4'b0010);
        checkOutput("t5_preempt", 32'(gnt), 32'h1);

        // Reset in the middle of a grant aborts it
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 4'b1111);
        applyStimulus(1'b1, 4'b0100, 4'b1111);
        applyStimulus(1'b0, 4'b1111, 4'b1111);
        checkOutput("t6_gnt", 32'(gnt),     32'h0);
        checkOutput("t6_z",   32'(z),       32'h0);
        checkOutput("t6_zv",  32'(z_valid), 32'h0);
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        checkOutput("t6_regnt", 32'(gnt), 32'h1);

        // Randomized traffic. Requests are sticky for a while, and reset is applied occasionally.
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                applyStimulus(($urandom_range(0, 59) != 0), r, 4'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
